integracao: RTL and testbench

Integrated datapath of the 8-bit stack CPU. It combines an 8-bit LIFO operand stack, a pop output register (outpilha), two temporary operand registers (tmp1, tmp2) and a combinational ALU. The control unit above it drives opcode, push, pop and load each cycle. Results written by the ALU are pushed back onto the stack.

---
 rtl/integracao.sv | 161 ++++++++++++++++
 tb/tb_integracao.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/integracao.sv
// Datapath of the 8-bit stack CPU: LIFO operand stack, pop register, two temporaries and a combinational ALU.
// Latency: stack/temporary updates take one core cycle; ALU result and carry are combinational from tmp1/tmp2.
// Backpressure: none; push while full and pop while empty are silently dropped. Optional MUL opcode behind ALU_MUL_EN.
module integracao #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] data,
    input  logic             push,
    input  logic             pop,
    input  logic             load,
    output logic             empty,
    output logic             full,
    output logic             carryout,
    output logic [WIDTH-1:0] s_ula,
    output logic [WIDTH-1:0] tmp1,
    output logic [WIDTH-1:0] tmp2,
    output logic [WIDTH-1:0] outpilha
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [4:0] OP_PUSH_D = 5'b00000;
    localparam logic [4:0] OP_PUSH_I = 5'b00001;
    localparam logic [4:0] OP_PUSH_T = 5'b00010;
    localparam logic [4:0] OP_ADD    = 5'b00100;
    localparam logic [4:0] OP_SUB    = 5'b00101;
    localparam logic [4:0] OP_AND    = 5'b00110;
    localparam logic [4:0] OP_OR     = 5'b00111;
    localparam logic [4:0] OP_XOR    = 5'b01000;
    localparam logic [4:0] OP_NOT    = 5'b01001;
    localparam logic [4:0] OP_SHL    = 5'b01010;
    localparam logic [4:0] OP_SHR    = 5'b01011;
`ifdef ALU_MUL_EN
    localparam logic [4:0] OP_MUL    = 5'b01100;
`endif

    // Architectural state
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] outpilha_q, outpilha_d;
    logic [WIDTH-1:0] tmp1_q, tmp1_d;
    logic [WIDTH-1:0] tmp2_q, tmp2_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Stack write port and helpers
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] push_src;
    logic [CW-1:0]    count_m1;
    logic [AW-1:0]    top_idx;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH:0]   alu_res;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mul_prod;
    assign mul_prod = tmp1_q * tmp2_q;
`endif

    // Flags decode straight from the registered count so they change one edge after the push/pop
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign tmp1     = tmp1_q;
    assign tmp2     = tmp2_q;
    assign outpilha = outpilha_q;
    assign s_ula    = alu_res[WIDTH-1:0];
    assign carryout = alu_res[WIDTH];

    // ALU: 9-bit result whose MSB is the carry/borrow/shift-out flag
    always_comb begin
        alu_res = {1'b0, tmp1_q};
        unique case (opcode)
            OP_ADD:  alu_res = {1'b0, tmp1_q} + {1'b0, tmp2_q};
            OP_SUB:  alu_res = {1'b0, tmp1_q} - {1'b0, tmp2_q};
            OP_AND:  alu_res = {1'b0, tmp1_q & tmp2_q};
            OP_OR:   alu_res = {1'b0, tmp1_q | tmp2_q};
            OP_XOR:  alu_res = {1'b0, tmp1_q ^ tmp2_q};
            OP_NOT:  alu_res = {1'b0, ~tmp1_q};
            OP_SHL:  alu_res = {tmp1_q, 1'b0};
            OP_SHR:  alu_res = {tmp1_q[0], 1'b0, tmp1_q[WIDTH-1:1]};
`ifdef ALU_MUL_EN
            OP_MUL:  alu_res = {|mul_prod[2*WIDTH-1:WIDTH], mul_prod[WIDTH-1:0]};
`endif
            default: alu_res = {1'b0, tmp1_q};
        endcase
    end

    // Push source selection; every non-push opcode feeds the ALU result back
    always_comb begin
        push_src = s_ula;
        unique case (opcode)
            OP_PUSH_D: push_src = data;
            OP_PUSH_I: push_src = imm;
            OP_PUSH_T: push_src = tmp1_q;
            default:   push_src = s_ula;
        endcase
    end

    // Stack control: push+pop on a non-empty stack replaces the top in place, even when full
    always_comb begin
        count_m1   = count_q - CW'(1);
        top_idx    = count_m1[AW-1:0];
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        count_d    = count_q;
        outpilha_d = outpilha_q;
        mem_we     = 1'b0;
        mem_waddr  = count_q[AW-1:0];
        if (do_pop) begin
            outpilha_d = mem_q[top_idx];
        end
        if (do_push && do_pop) begin
            mem_we    = 1'b1;
            mem_waddr = top_idx;
        end else if (do_push) begin
            mem_we    = 1'b1;
            mem_waddr = count_q[AW-1:0];
            count_d   = count_q + CW'(1);
        end else if (do_pop) begin
            count_d   = count_m1;
        end
    end

    // Temporaries shift on load, using the pre-edge outpilha
    always_comb begin
        tmp1_d = tmp1_q;
        tmp2_d = tmp2_q;
        if (load) begin
            tmp1_d = outpilha_q;
            tmp2_d = tmp1_q;
        end
    end

    // Stack storage needs no reset: entries above the count are never read
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= push_src;
        end
    end

    // Control state registers with asynchronous clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q    <= '0;
            outpilha_q <= '0;
            tmp1_q     <= '0;
            tmp2_q     <= '0;
        end else begin
            count_q    <= count_d;
            outpilha_q <= outpilha_d;
            tmp1_q     <= tmp1_d;
            tmp2_q     <= tmp2_d;
        end
    end

endmodule

// File: tb/tb_integracao.sv
// Bench for the stack CPU datapath: directed command sequences with hand-computed results.
// Stimulus queues expectations; a negedge monitor pops and compares them against the DUT.
// No handshakes in the DUT, so every expectation is checked one half-cycle after being queued.
module tb_integracao;

    localparam logic [4:0] OP_D   = 5'b00000;
    localparam logic [4:0] OP_I   = 5'b00001;
    localparam logic [4:0] OP_T   = 5'b00010;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_SUB = 5'b00101;
    localparam logic [4:0] OP_AND = 5'b00110;
    localparam logic [4:0] OP_OR  = 5'b00111;
    localparam logic [4:0] OP_XOR = 5'b01000;
    localparam logic [4:0] OP_NOT = 5'b01001;
    localparam logic [4:0] OP_SHL = 5'b01010;
    localparam logic [4:0] OP_SHR = 5'b01011;
    localparam logic [4:0] OP_MUL = 5'b01100;
    localparam logic [4:0] OP_DEF = 5'b01101;

    localparam int S_EMPTY = 0;
    localparam int S_FULL  = 1;
    localparam int S_CARRY = 2;
    localparam int S_ULA   = 3;
    localparam int S_TMP1  = 4;
    localparam int S_TMP2  = 5;
    localparam int S_OUTP  = 6;

    localparam int TIMEOUT = 100000;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] opcode;
    logic [7:0] imm;
    logic [7:0] data;
    logic       push;
    logic       pop;
    logic       load;
    logic       empty;
    logic       full;
    logic       carryout;
    logic [7:0] s_ula;
    logic [7:0] tmp1;
    logic [7:0] tmp2;
    logic [7:0] outpilha;

    typedef struct {
        string name;
        int    sel;
        int    exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    integracao #(.WIDTH(8), .DEPTH(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .opcode   (opcode),
        .imm      (imm),
        .data     (data),
        .push     (push),
        .pop      (pop),
        .load     (load),
        .empty    (empty),
        .full     (full),
        .carryout (carryout),
        .s_ula    (s_ula),
        .tmp1     (tmp1),
        .tmp2     (tmp2),
        .outpilha (outpilha)
    );

    always #5 clk = ~clk;

    function automatic int actual(input int sel);
        case (sel)
            S_EMPTY: return int'(empty);
            S_FULL:  return int'(full);
            S_CARRY: return int'(carryout);
            S_ULA:   return int'(s_ula);
            S_TMP1:  return int'(tmp1);
            S_TMP2:  return int'(tmp2);
            S_OUTP:  return int'(outpilha);
            default: return -1;
        endcase
    endfunction

    // Monitor: drain every queued expectation at the falling edge
    always @(negedge clk) begin
        exp_t e;
        int   act;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = actual(e.sel);
            checks++;
            if (act != e.exp) begin
                failures++;
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", e.name, act, e.exp, $time);
            end
        end
    end

    // Watchdog: a run that never finishes counts as a failure
    initial begin
        #(TIMEOUT);
        checks++;
        failures++;
        $display("FAIL timeout: bench did not finish within %0d time units", TIMEOUT);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic expect_sig(input string nm, input int sel, input int exp);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_now(input string nm, input int sel, input int exp);
        int act;
        act = actual(sel);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s (direct): got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    // One command cycle: drive, take the rising edge, then drop the strobes
    task automatic op(input logic [4:0] opc, input logic [7:0] i, input logic [7:0] d,
                      input logic pu, input logic po, input logic lo);
        opcode = opc;
        imm    = i;
        data   = d;
        push   = pu;
        pop    = po;
        load   = lo;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        load = 1'b0;
    endtask

    task automatic alu(input string nm, input logic [4:0] opc, input int res, input int cy);
        opcode = opc;
        expect_sig({nm, "_s_ula"}, S_ULA, res);
        expect_sig({nm, "_carry"}, S_CARRY, cy);
        sync();
    endtask

    initial begin
        rstn   = 1'b0;
        opcode = OP_D;
        imm    = '0;
        data   = '0;
        push   = 1'b0;
        pop    = 1'b0;
        load   = 1'b0;

        // Reset state, held for 30 time units
        expect_sig("rst_empty", S_EMPTY, 1);
        expect_sig("rst_full", S_FULL, 0);
        expect_sig("rst_outp", S_OUTP, 0);
        expect_sig("rst_tmp1", S_TMP1, 0);
        expect_sig("rst_tmp2", S_TMP2, 0);
        sync();
        check_now("rst_empty", S_EMPTY, 1);
        check_now("rst_full", S_FULL, 0);
        check_now("rst_outp", S_OUTP, 0);
        check_now("rst_tmp1", S_TMP1, 0);
        check_now("rst_tmp2", S_TMP2, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_sig("idle_empty", S_EMPTY, 1);
        expect_sig("idle_outp", S_OUTP, 0);
        expect_sig("idle_tmp1", S_TMP1, 0);
        sync();

        // push_i 12, 15; pop/load twice; ADD and push back
        op(OP_I, 8'd12, 8'd0, 1, 0, 0);
        op(OP_I, 8'd15, 8'd0, 1, 0, 0);
        expect_sig("pushi_empty", S_EMPTY, 0);
        sync();
        op(OP_I, 8'd0, 8'd0, 0, 1, 0);
        expect_sig("pop1_outp", S_OUTP, 15);
        sync();
        op(OP_I, 8'd0, 8'd0, 0, 0, 1);
        expect_sig("load1_tmp1", S_TMP1, 15);
        sync();
        op(OP_I, 8'd0, 8'd0, 0, 1, 0);
        expect_sig("pop2_outp", S_OUTP, 12);
        expect_sig("pop2_empty", S_EMPTY, 1);
        sync();
        op(OP_I, 8'd0, 8'd0, 0, 0, 1);
        expect_sig("load2_tmp1", S_TMP1, 12);
        expect_sig("load2_tmp2", S_TMP2, 15);
        sync();
        alu("add27", OP_ADD, 27, 0);
        op(OP_ADD, 8'd0, 8'd0, 1, 0, 0);
        expect_sig("pushalu_empty", S_EMPTY, 0);
        sync();
        op(OP_ADD, 8'd0, 8'd0, 0, 1, 0);
        expect_sig("popalu_outp", S_OUTP, 27);
        expect_sig("popalu_empty", S_EMPTY, 1);
        sync();

        // push_d 100, 200 -> tmp1=100, tmp2=200; full ALU sweep
        op(OP_D, 8'd0, 8'd100, 1, 0, 0);
        op(OP_D, 8'd0, 8'd200, 1, 0, 0);
        op(OP_D, 8'd0, 8'd0, 0, 1, 0);
        expect_sig("popd_outp", S_OUTP, 200);
        sync();
        op(OP_D, 8'd0, 8'd0, 0, 0, 1);
        op(OP_D, 8'd0, 8'd0, 0, 1, 0);
        op(OP_D, 8'd0, 8'd0, 0, 0, 1);
        expect_sig("ld_tmp1_100", S_TMP1, 100);
        expect_sig("ld_tmp2_200", S_TMP2, 200);
        sync();
        alu("add300", OP_ADD, 44, 1);
        alu("sub", OP_SUB, 156, 1);
        alu("and", OP_AND, 64, 0);
        alu("or", OP_OR, 236, 0);
        alu("xor", OP_XOR, 172, 0);
        alu("not", OP_NOT, 155, 0);
        alu("shl100", OP_SHL, 200, 0);
        alu("shr100", OP_SHR, 50, 0);
        alu("default", OP_DEF, 100, 0);
`ifdef ALU_MUL_EN
        alu("mul100x200", OP_MUL, 32, 1);
`else
        alu("op01100_dflt", OP_MUL, 100, 0);
`endif

        // Fill to DEPTH, overflow push, drain, underflow pop
        for (int k = 1; k <= 8; k++) begin
            op(OP_I, 8'(k), 8'd0, 1, 0, 0);
        end
        expect_sig("fill_full", S_FULL, 1);
        expect_sig("fill_empty", S_EMPTY, 0);
        sync();
        op(OP_I, 8'd99, 8'd0, 1, 0, 0);
        expect_sig("ovf_full", S_FULL, 1);
        sync();
        op(OP_I, 8'd0, 8'd0, 0, 1, 0);
        expect_sig("ovf_top", S_OUTP, 8);
        expect_sig("ovf_full_clr", S_FULL, 0);
        sync();
        repeat (7) op(OP_I, 8'd0, 8'd0, 0, 1, 0);
        expect_sig("drain_outp", S_OUTP, 1);
        expect_sig("drain_empty", S_EMPTY, 1);
        sync();
        op(OP_I, 8'd0, 8'd0, 0, 1, 0);
        expect_sig("unf_outp", S_OUTP, 1);
        expect_sig("unf_empty", S_EMPTY, 1);
        sync();

        // push_t with tmp1=12, then simultaneous push+pop
        op(OP_I, 8'd12, 8'd0, 1, 0, 0);
        op(OP_I, 8'd0, 8'd0, 0, 1, 0);
        op(OP_I, 8'd0, 8'd0, 0, 0, 1);
        expect_sig("pt_tmp1", S_TMP1, 12);
        sync();
        op(OP_T, 8'd0, 8'd0, 1, 0, 0);
        op(OP_I, 8'd7, 8'd0, 1, 0, 0);
        op(OP_I, 8'd55, 8'd0, 1, 1, 0);
        expect_sig("pp_outp", S_OUTP, 7);
        expect_sig("pp_empty", S_EMPTY, 0);
        sync();
        op(OP_I, 8'd0, 8'd0, 0, 1, 0);
        expect_sig("pp_newtop", S_OUTP, 55);
        expect_sig("pp_cnt_empty", S_EMPTY, 0);
        sync();
        op(OP_I, 8'd0, 8'd0, 0, 1, 0);
        expect_sig("pt_top", S_OUTP, 12);
        expect_sig("pt_empty", S_EMPTY, 1);
        sync();
        op(OP_I, 8'd77, 8'd0, 1, 1, 0);
        expect_sig("ppe_outp", S_OUTP, 12);
        expect_sig("ppe_empty", S_EMPTY, 0);
        sync();
        op(OP_I, 8'd0, 8'd0, 0, 1, 0);
        expect_sig("ppe_pop", S_OUTP, 77);
        sync();

        // tmp1=16, tmp2=20 for the multiply opcode
        op(OP_I, 8'd16, 8'd0, 1, 0, 0);
        op(OP_I, 8'd20, 8'd0, 1, 0, 0);
        op(OP_I, 8'd0, 8'd0, 0, 1, 0);
        op(OP_I, 8'd0, 8'd0, 0, 0, 1);
        op(OP_I, 8'd0, 8'd0, 0, 1, 0);
        op(OP_I, 8'd0, 8'd0, 0, 0, 1);
        expect_sig("m_tmp1", S_TMP1, 16);
        expect_sig("m_tmp2", S_TMP2, 20);
        sync();
`ifdef ALU_MUL_EN
        alu("mul16x20", OP_MUL, 64, 1);
`else
        alu("mul_off", OP_MUL, 16, 0);
`endif

        // Shift-out carries with tmp1=129
        op(OP_I, 8'd129, 8'd0, 1, 0, 0);
        op(OP_I, 8'd0, 8'd0, 0, 1, 0);
        op(OP_I, 8'd0, 8'd0, 0, 0, 1);
        alu("shl129", OP_SHL, 2, 1);
        alu("shr129", OP_SHR, 64, 1);

        // Pop and load together: load takes the pre-edge outpilha
        op(OP_I, 8'd5, 8'd0, 1, 0, 0);
        op(OP_I, 8'd0, 8'd0, 0, 1, 1);
        expect_sig("pl_tmp1", S_TMP1, 129);
        expect_sig("pl_tmp2", S_TMP2, 129);
        expect_sig("pl_outp", S_OUTP, 5);
        sync();

        // Asynchronous reset in the middle of a push+load
        op(OP_I, 8'd9, 8'd0, 1, 0, 0);
        push = 1'b1;
        load = 1'b1;
        #1;
        rstn = 1'b0;
        #1;
        expect_sig("mid_empty", S_EMPTY, 1);
        expect_sig("mid_outp", S_OUTP, 0);
        expect_sig("mid_tmp1", S_TMP1, 0);
        expect_sig("mid_tmp2", S_TMP2, 0);
        sync();
        push = 1'b0;
        load = 1'b0;
        rstn = 1'b1;

        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
